// File: rtl/timer_counter.sv
// timer_counter: memory-mapped 32-bit down-counting timer.
// Registers: CTRL (EN/AR/IE/PRESCALE), LOAD, COUNT (read-only), STATUS (TF, W1C).
// Reads are combinational on the shared peripheral bus; state changes on rising clk.
// Optional feature macro: TC_PRESCALER_EN enables the prescaler counter and makes
// the CTRL PRESCALE field read/write. Without it the timer ticks every cycle
// while enabled and the PRESCALE field reads as zero.
module timer_counter #(
    parameter int PRESCALE_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        CS_N,
    input  logic        WE,
    input  logic [11:0] Addr,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        Intr
);

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_LOAD   = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;
    localparam logic [1:0] OFF_STATUS = 2'd3;

    logic        en_r;
    logic        ar_r;
    logic        ie_r;
    logic        tf_r;
    logic [31:0] load_r;
    logic [31:0] count_r;

    logic        sel_s;
    logic        wr_s;
    logic        wr_ctrl_s;
    logic        wr_load_s;
    logic        wr_status_s;
    logic        tick_s;
    logic        count_zero_s;
    logic        expire_s;
    logic [31:0] ctrl_rd_s;
    logic [31:0] rd_data_s;
    logic        unused_addr_s;

    // Only the low 16 bytes of the window are mapped; byte lanes are not decoded.
    assign sel_s       = ~CS_N & (Addr[11:4] == 8'd0);
    assign wr_s        = sel_s & WE;
    assign wr_ctrl_s   = wr_s & (Addr[3:2] == OFF_CTRL);
    assign wr_load_s   = wr_s & (Addr[3:2] == OFF_LOAD);
    assign wr_status_s = wr_s & (Addr[3:2] == OFF_STATUS);

    assign count_zero_s  = (count_r == 32'd0);
    assign expire_s      = tick_s & count_zero_s;
    assign unused_addr_s = ^Addr[1:0];

`ifdef TC_PRESCALER_EN
    localparam logic [PRESCALE_W-1:0] PC_ZERO = {PRESCALE_W{1'b0}};
    localparam logic [PRESCALE_W-1:0] PC_ONE  = {{(PRESCALE_W-1){1'b0}}, 1'b1};

    logic [PRESCALE_W-1:0] prescale_r;
    logic [PRESCALE_W-1:0] pc_r;
    logic                  en_rise_s;

    // A tick fires when the prescaler counter reaches the programmed divide value.
    assign tick_s    = en_r & (pc_r == prescale_r);
    assign en_rise_s = wr_ctrl_s & DataIn[0] & ~en_r;

    // PRESCALE field changes only on CTRL writes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescale_r <= PC_ZERO;
        end else if (wr_ctrl_s) begin
            prescale_r <= DataIn[8 +: PRESCALE_W];
        end else begin
            prescale_r <= prescale_r;
        end
    end

    // Prescaler counter: cleared by LOAD writes, EN rising or a tick; otherwise counts
    // while enabled. Lowering PRESCALE below PC lets PC wrap through all-ones to zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_r <= PC_ZERO;
        end else if (wr_load_s || en_rise_s) begin
            pc_r <= PC_ZERO;
        end else if (tick_s) begin
            pc_r <= PC_ZERO;
        end else if (en_r) begin
            pc_r <= pc_r + PC_ONE;
        end else begin
            pc_r <= pc_r;
        end
    end

    // CTRL readback including the PRESCALE field.
    always_comb begin
        ctrl_rd_s                   = 32'd0;
        ctrl_rd_s[0]                = en_r;
        ctrl_rd_s[1]                = ar_r;
        ctrl_rd_s[2]                = ie_r;
        ctrl_rd_s[8 +: PRESCALE_W]  = prescale_r;
    end
`else
    logic unused_cfg_s;

    // Without a prescaler every enabled cycle is a tick.
    assign tick_s       = en_r;
    assign unused_cfg_s = (PRESCALE_W > 0);

    // CTRL readback; the PRESCALE field does not exist in this build.
    always_comb begin
        ctrl_rd_s    = 32'd0;
        ctrl_rd_s[0] = en_r;
        ctrl_rd_s[1] = ar_r;
        ctrl_rd_s[2] = ie_r;
    end
`endif

    // CTRL flags: a CTRL write on the expiry edge overrides the one-shot auto-disable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_r <= 1'b0;
            ar_r <= 1'b0;
            ie_r <= 1'b0;
        end else if (wr_ctrl_s) begin
            en_r <= DataIn[0];
            ar_r <= DataIn[1];
            ie_r <= DataIn[2];
        end else if (expire_s && !ar_r) begin
            en_r <= 1'b0;
            ar_r <= ar_r;
            ie_r <= ie_r;
        end else begin
            en_r <= en_r;
            ar_r <= ar_r;
            ie_r <= ie_r;
        end
    end

    // Reload value register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_r <= 32'd0;
        end else if (wr_load_s) begin
            load_r <= DataIn;
        end else begin
            load_r <= load_r;
        end
    end

    // Down counter: a LOAD write beats a coincident tick; on expiry reload or park at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= 32'd0;
        end else if (wr_load_s) begin
            count_r <= DataIn;
        end else if (tick_s) begin
            if (!count_zero_s) begin
                count_r <= count_r - 32'd1;
            end else if (ar_r) begin
                count_r <= load_r;
            end else begin
                count_r <= 32'd0;
            end
        end else begin
            count_r <= count_r;
        end
    end

    // Sticky expiry flag: setting on expiry beats a coincident write-1-to-clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tf_r <= 1'b0;
        end else if (expire_s) begin
            tf_r <= 1'b1;
        end else if (wr_status_s && DataIn[0]) begin
            tf_r <= 1'b0;
        end else begin
            tf_r <= tf_r;
        end
    end

    // Zero-wait-state read mux; deselected or unmapped accesses return zero.
    always_comb begin
        rd_data_s = 32'd0;
        if (sel_s) begin
            case (Addr[3:2])
                OFF_CTRL:   rd_data_s = ctrl_rd_s;
                OFF_LOAD:   rd_data_s = load_r;
                OFF_COUNT:  rd_data_s = count_r;
                OFF_STATUS: rd_data_s = {31'd0, tf_r};
                default:    rd_data_s = 32'd0;
            endcase
        end else begin
            rd_data_s = 32'd0;
        end
    end

    assign DataOut = rd_data_s;
    assign Intr    = tf_r & ie_r;

endmodule
